// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: four-way intersection phase sequencer.
// A divided tick drives a per-phase countdown (time_left); each phase lasts
// duration+1 ticks. Lamp outputs are registered from the next state so they
// change in the same cycle as the state register.
// Optional feature: define PED_REQ_EN to compile in the pedestrian request
// latch, green-phase clamp and the PED_WALK phase.
module traffic_phase_scheduler #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned GREEN_T  = 10,
    parameter int unsigned YELLOW_T = 5,
    parameter int unsigned ALLRED_T = 1,
    parameter int unsigned WALK_T   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       ped_req,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk,
    output logic       ped_ack,
    output logic [3:0] time_left,
    output logic       tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    localparam logic [1:0] LAMP_RED = 2'b00;
    localparam logic [1:0] LAMP_YEL = 2'b01;
    localparam logic [1:0] LAMP_GRN = 2'b10;

    localparam logic [3:0] CLAMP_T = 4'd3;

`ifdef PED_REQ_EN
    typedef enum logic [2:0] {
        NS_GREEN, NS_YELLOW, ALL_RED_A, EW_GREEN, EW_YELLOW, ALL_RED_B, PED_WALK
    } state_t;
`else
    typedef enum logic [2:0] {
        NS_GREEN, NS_YELLOW, ALL_RED_A, EW_GREEN, EW_YELLOW, ALL_RED_B
    } state_t;
`endif

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   tick_cnt;
    logic            advance;
    logic [3:0]      next_dur;
    logic [3:0]      tl_base;
    logic [3:0]      tl_nx;
    logic [1:0]      ns_nx;
    logic [1:0]      ew_nx;

`ifdef PED_REQ_EN
    logic            ped_q;
    logic            pending;
    logic            clamp_done;
    logic            ped_accept;
    logic            clamp_arm;
    logic            walk_nx;
`endif

    // Tick divider: free-runs 0..TICK_DIV-1 while run is high, frozen otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (run) begin
            tick_cnt <= (tick_cnt == CNT_MAX) ? '0 : tick_cnt + 1'b1;
        end
    end

    // Tick strobe: high in the cycle whose clock edge wraps the divider
    always_comb begin
        tick = run && !rst && (tick_cnt == CNT_MAX);
    end

    // State register and phase countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ALL_RED_B;
            time_left <= 4'(ALLRED_T);
        end else begin
            state     <= state_nx;
            time_left <= tl_nx;
        end
    end

    // Next state and next countdown value; the clamp is applied on top of the
    // decremented value so a same-cycle tick and request both take effect
    always_comb begin
        advance  = tick && (time_left == '0);
        state_nx = state;
        if (advance) begin
            case (state)
                NS_GREEN:  state_nx = NS_YELLOW;
                NS_YELLOW: state_nx = ALL_RED_A;
                ALL_RED_A: state_nx = EW_GREEN;
                EW_GREEN:  state_nx = EW_YELLOW;
                EW_YELLOW: state_nx = ALL_RED_B;
`ifdef PED_REQ_EN
                ALL_RED_B: state_nx = pending ? PED_WALK : NS_GREEN;
                PED_WALK:  state_nx = NS_GREEN;
`else
                ALL_RED_B: state_nx = NS_GREEN;
`endif
                default:   state_nx = NS_GREEN;
            endcase
        end

        case (state_nx)
            NS_GREEN, EW_GREEN:   next_dur = 4'(GREEN_T);
            NS_YELLOW, EW_YELLOW: next_dur = 4'(YELLOW_T);
`ifdef PED_REQ_EN
            PED_WALK:             next_dur = 4'(WALK_T);
`endif
            default:              next_dur = 4'(ALLRED_T);
        endcase

        tl_base = time_left;
        if (tick) begin
            tl_base = advance ? next_dur : time_left - 4'd1;
        end

        tl_nx = tl_base;
`ifdef PED_REQ_EN
        clamp_arm = run && pending && !clamp_done && !advance &&
                    ((state == NS_GREEN) || (state == EW_GREEN));
        if (clamp_arm && (tl_base > CLAMP_T)) begin
            tl_nx = CLAMP_T;
        end
`endif
    end

    // Lamp decode of the next state, registered below
    always_comb begin
        ns_nx = LAMP_RED;
        ew_nx = LAMP_RED;
        case (state_nx)
            NS_GREEN:  ns_nx = LAMP_GRN;
            NS_YELLOW: ns_nx = LAMP_YEL;
            EW_GREEN:  ew_nx = LAMP_GRN;
            EW_YELLOW: ew_nx = LAMP_YEL;
            default: begin
                ns_nx = LAMP_RED;
                ew_nx = LAMP_RED;
            end
        endcase
`ifdef PED_REQ_EN
        walk_nx = (state_nx == PED_WALK);
`endif
    end

    // Lamp output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ns_light <= LAMP_RED;
            ew_light <= LAMP_RED;
        end else begin
            ns_light <= ns_nx;
            ew_light <= ew_nx;
        end
    end

`ifdef PED_REQ_EN
    always_comb begin
        ped_accept = ped_req && !ped_q && !pending && (state != PED_WALK);
    end

    // Pedestrian request latch, acknowledge pulse, per-green clamp flag, walk lamp
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_q      <= 1'b0;
            pending    <= 1'b0;
            clamp_done <= 1'b0;
            ped_ack    <= 1'b0;
            walk       <= 1'b0;
        end else begin
            ped_q   <= ped_req;
            ped_ack <= ped_accept;
            walk    <= walk_nx;
            if (advance && (state_nx == PED_WALK)) begin
                pending <= 1'b0;
            end else if (ped_accept) begin
                pending <= 1'b1;
            end
            if (advance) begin
                clamp_done <= 1'b0;
            end else if (clamp_arm) begin
                clamp_done <= 1'b1;
            end
        end
    end
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign walk           = 1'b0;
    assign ped_ack        = 1'b0;
`endif

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 100000000, SHALL set the clk cycles per timing tick (1 s at 100 MHz).
REQ-002 Parameters GREEN_T, YELLOW_T, ALLRED_T and WALK_T, defaults 10, 5, 1 and 8, SHALL each be a phase duration in ticks, with legal range 1..15.
REQ-003 clk  input  1  SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 run  input  1  SHALL enable phase sequencing; when low, the tick counter and phase timer freeze.
REQ-006 ped_req  input  1  SHALL be the pedestrian request level, assumed synchronous to clk.
REQ-007 ns_light  output  2  SHALL be the north-south lamp code: 00 red, 01 yellow, 10 green (11 never driven).
REQ-008 ew_light  output  2  SHALL be the east-west lamp code, encoded as ns_light.
REQ-009 walk  output  1  SHALL be high only in PED_WALK.
REQ-010 ped_ack  output  1  SHALL be a one-cycle pulse acknowledging a latched request.
REQ-011 time_left  output  4  SHALL be the remaining ticks in the current phase, for the 7-segment driver.
REQ-012 tick  output  1  SHALL be a one-cycle strobe marking each timing tick.

Function
REQ-013 The tick counter SHALL count 0..TICK_DIV-1 while run=1; tick SHALL pulse in the cycle the count wraps to 0.
REQ-014 The states SHALL be NS_GREEN, NS_YELLOW, ALL_RED_A, EW_GREEN, EW_YELLOW, ALL_RED_B, PED_WALK.
REQ-015 Lamps SHALL be driven as follows, registered and changing in the same cycle as the state: NS_GREEN ns=10/ew=00; NS_YELLOW ns=01/ew=00; EW_GREEN ns=00/ew=10; EW_YELLOW ns=00/ew=01; ALL_RED_A, ALL_RED_B and PED_WALK ns=00/ew=00.
REQ-016 On a tick with time_left>0, time_left SHALL decrement by 1.
REQ-017 On a tick with time_left==0, the state SHALL advance and time_left SHALL load the next state's duration, so each phase lasts duration+1 ticks.
REQ-018 The advance order SHALL be NS_GREEN->NS_YELLOW->ALL_RED_A->EW_GREEN->EW_YELLOW->ALL_RED_B->(PED_WALK if pending, else NS_GREEN), with PED_WALK->NS_GREEN.
REQ-019 A rising edge on ped_req SHALL set pending and pulse ped_ack for exactly 1 cycle in the next cycle; if pending is already set, or the state is PED_WALK, the edge SHALL be ignored with no ack.
REQ-020 If pending is set while in NS_GREEN or EW_GREEN with time_left>3, time_left SHALL be clamped to 3 on the next cycle, once per green phase; the clamp SHALL never lengthen a phase.
REQ-021 pending SHALL clear in the cycle PED_WALK is entered.
REQ-022 If a ped_req rising edge and a tick occur in the same cycle, both SHALL take effect, and the clamp of REQ-020 SHALL apply after the decrement.
REQ-023 While run=0, state, time_left and lamps SHALL hold, tick SHALL stay low, and requests SHALL still latch and ack.
REQ-024 time_left SHALL never wrap below 0 and SHALL never exceed 15.

Reset
REQ-025 While rst is high: state=ALL_RED_B, time_left=ALLRED_T, ns_light=00, ew_light=00, walk=0, ped_ack=0, tick=0, pending=0, tick counter=0.
REQ-026 Reset asserted mid-phase SHALL discard any pending request and any clamp immediately, without waiting for a clk edge.
REQ-027 After rst deasserts, sequencing SHALL resume from ALL_RED_B on the first rising clk edge with run=1, so the first green is NS_GREEN.

Configuration
REQ-028 Macro PED_REQ_EN defined: the pedestrian logic of REQ-018 to REQ-022 SHALL be compiled in.
REQ-029 Macro PED_REQ_EN undefined: ped_req SHALL be ignored, walk and ped_ack SHALL be tied 0, PED_WALK SHALL not exist, and ALL_RED_B SHALL always advance to NS_GREEN.

Verification (TICK_DIV=4, defaults otherwise)
REQ-030 Release reset with run=1 and no requests -> after 2 ticks, NS_GREEN with time_left=10; full cycle of 11+6+2+11+6+2 = 38 ticks repeats with no walk.
REQ-031 Pulse ped_req during NS_GREEN at time_left=8 -> ped_ack high for 1 cycle, time_left=3 next cycle, and PED_WALK (walk=1, time_left=8) follows ALL_RED_B.
REQ-032 Issue a second ped_req edge while pending, and another during PED_WALK -> no ped_ack for either, and only one PED_WALK occurs.
REQ-033 Hold run=0 for 20 cycles in EW_YELLOW -> tick stays low, time_left and lamps are unchanged, and the sequence resumes exactly where it stopped.
REQ-034 Assert rst mid-EW_GREEN while pending -> outputs take reset values asynchronously, and no PED_WALK occurs afterwards.
REQ-035 Build without PED_REQ_EN and toggle ped_req -> walk and ped_ack stay 0, and the 38-tick cycle is unchanged.
